// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one registered memory port; completion pulse one cycle after mem_ack.
// Optional access timeout with sticky err when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        grant_d,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;
  logic        timeout_hit;
  logic        if_eff, d_eff;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // A requester whose completion pulse is showing this cycle is not re-granted yet.
  assign if_eff = if_req & ~if_ready_q;
  assign d_eff  = d_req & ~d_valid_q;

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_wmask_d = mem_wmask_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_valid_d   = 1'b0;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // Data wins contention unless data owned the port last.
        if (d_eff && (!if_eff || !last_d_q)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_wmask_d = d_wmask;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else if (if_eff) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_wmask_d = 4'h0;
          mem_addr_d  = if_addr;
          mem_wdata_d = 32'h0;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ack || timeout_hit) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          last_d_d  = (state_q == BUSY_D);
          if (state_q == BUSY_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = mem_ack ? mem_rdata : 32'h0;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : 32'h0;
          end
          if (!mem_ack) err_d = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wmask_q <= 4'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= 32'h0;
      err_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wmask_q <= mem_wmask_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_d   = (state_q == BUSY_D);
  assign err       = err_q;

endmodule
